// File: rtl/chao_ranging_ctrl.sv
// Ultrasonic ranging sequencer: trigger pulse, echo timing, divider-free cm conversion.
// Optional CHAO_AVG_EN: dist_cm becomes the mean of the last four valid results.
module chao_ranging_ctrl #(
    parameter int TRIG_CYCLES    = 500,
    parameter int US_DIV         = 50,
    parameter int CM_US          = 58,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int DIST_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              echo,
    output logic              trig,
    output logic              busy,
    output logic [DIST_W-1:0] dist_cm,
    output logic              valid,
    output logic              timeout
);

    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int US_W  = $clog2(US_DIV + 1);
    localparam int SUB_W = $clog2(CM_US + 1);

    localparam logic [PER_W-1:0]  TRIG_END = PER_W'(TRIG_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_END  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_MAX  = '1;
    localparam logic [TO_W-1:0]   TO_END   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = '1;
    localparam logic [US_W-1:0]   US_END   = US_W'(US_DIV - 1);
    localparam logic [SUB_W-1:0]  SUB_END  = SUB_W'(CM_US - 1);
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic              echo_meta_reg, echo_sync_reg, echo_prev_reg;
    logic              echo_rise, echo_fall;
    logic [PER_W-1:0]  period_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [US_W-1:0]   us_cnt_reg;
    logic [SUB_W-1:0]  sub_cnt_reg;
    logic [DIST_W-1:0] cm_cnt_reg, cm_cnt_next;
    logic              us_tick, cm_tick;
    logic              trig_done, period_done, to_hit;
    logic              meas_done, meas_abort;
    logic              enter_trig, enter_wait, enter_meas;
    logic [DIST_W-1:0] dist_cm_reg;
    logic              valid_reg, timeout_reg;

    // Echo pin is asynchronous to clk: two flops for metastability, a third for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_reg <= 1'b0;
            echo_sync_reg <= 1'b0;
            echo_prev_reg <= 1'b0;
        end else begin
            echo_meta_reg <= echo;
            echo_sync_reg <= echo_meta_reg;
            echo_prev_reg <= echo_sync_reg;
        end
    end

    assign echo_rise = echo_sync_reg & ~echo_prev_reg;
    assign echo_fall = ~echo_sync_reg & echo_prev_reg;

    assign trig_done   = (period_cnt_reg >= TRIG_END);
    assign period_done = (period_cnt_reg >= PER_END);
    assign to_hit      = (to_cnt_reg >= TO_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (en) state_next = S_TRIG;
            end
            S_TRIG: begin
                if (trig_done) state_next = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                if (echo_rise)   state_next = S_MEASURE;
                else if (to_hit) state_next = S_HOLDOFF;
            end
            S_MEASURE: begin
                if (echo_fall || to_hit) state_next = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (period_done) state_next = en ? S_TRIG : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        trig = (state_reg == S_TRIG);
        busy = (state_reg != S_IDLE);
    end

    assign enter_trig = (state_next == S_TRIG) && (state_reg != S_TRIG);
    assign enter_wait = (state_reg == S_TRIG) && (state_next == S_WAIT_ECHO);
    assign enter_meas = (state_reg == S_WAIT_ECHO) && (state_next == S_MEASURE);
    assign meas_done  = (state_reg == S_MEASURE) && echo_fall;
    assign meas_abort = ((state_reg == S_WAIT_ECHO) || (state_reg == S_MEASURE))
                        && (state_next == S_HOLDOFF) && !meas_done;

    // The cycle that sees the falling edge still counts, so the result folds in its own tick.
    assign us_tick     = (us_cnt_reg == US_END);
    assign cm_tick     = us_tick && (sub_cnt_reg == SUB_END);
    assign cm_cnt_next = (cm_tick && (cm_cnt_reg != DIST_MAX)) ? cm_cnt_reg + 1'b1 : cm_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_reg <= '0;
            to_cnt_reg     <= '0;
            us_cnt_reg     <= '0;
            sub_cnt_reg    <= '0;
            cm_cnt_reg     <= '0;
        end else begin
            if (enter_trig) begin
                period_cnt_reg <= '0;
            end else if ((state_reg != S_IDLE) && (period_cnt_reg != PER_MAX)) begin
                period_cnt_reg <= period_cnt_reg + 1'b1;
            end

            if (enter_wait) begin
                to_cnt_reg <= '0;
            end else if (((state_reg == S_WAIT_ECHO) || (state_reg == S_MEASURE))
                         && (to_cnt_reg != TO_MAX)) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end

            if (enter_meas) begin
                us_cnt_reg  <= '0;
                sub_cnt_reg <= '0;
                cm_cnt_reg  <= '0;
            end else if (state_reg == S_MEASURE) begin
                us_cnt_reg <= us_tick ? '0 : us_cnt_reg + 1'b1;
                if (us_tick) begin
                    sub_cnt_reg <= (sub_cnt_reg == SUB_END) ? '0 : sub_cnt_reg + 1'b1;
                end
                cm_cnt_reg <= cm_cnt_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= meas_abort;
        end
    end

`ifdef CHAO_AVG_EN
    logic [DIST_W-1:0] win_reg [4];
    logic              primed_reg;
    logic              avg_pend_reg;
    logic [DIST_W+1:0] win_sum;

    always_comb begin
        win_sum = '0;
        for (int i = 0; i < 4; i++) begin
            win_sum = win_sum + {2'b00, win_reg[i]};
        end
    end

    // First result after reset seeds the whole window so the mean starts at that sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                win_reg[i] <= '0;
            end
            primed_reg   <= 1'b0;
            avg_pend_reg <= 1'b0;
            dist_cm_reg  <= '0;
            valid_reg    <= 1'b0;
        end else begin
            avg_pend_reg <= meas_done;
            valid_reg    <= avg_pend_reg;
            if (meas_done) begin
                primed_reg <= 1'b1;
                win_reg[0] <= cm_cnt_next;
                for (int i = 1; i < 4; i++) begin
                    win_reg[i] <= primed_reg ? win_reg[i-1] : cm_cnt_next;
                end
            end
            if (avg_pend_reg) begin
                dist_cm_reg <= win_sum[DIST_W+1:2];
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_cm_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= meas_done;
            if (meas_done) begin
                dist_cm_reg <= cm_cnt_next;
            end
        end
    end
`endif

    assign dist_cm = dist_cm_reg;
    assign valid   = valid_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_chao_ranging_ctrl.sv
// Self-checking bench for chao_ranging_ctrl: directed scenarios plus random echo widths vs a distance model.
module tb_chao_ranging_ctrl;

    localparam int TRIG_CYCLES    = 10;
    localparam int US_DIV         = 2;
    localparam int CM_US          = 58;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int PERIOD_CYCLES  = 2000;
    localparam int DIST_W         = 16;
`ifdef CHAO_AVG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              echo;
    logic              trig;
    logic              busy;
    logic [DIST_W-1:0] dist_cm;
    logic              valid;
    logic              timeout;

    chao_ranging_ctrl #(
        .TRIG_CYCLES   (TRIG_CYCLES),
        .US_DIV        (US_DIV),
        .CM_US         (CM_US),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .DIST_W        (DIST_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .echo   (echo),
        .trig   (trig),
        .busy   (busy),
        .dist_cm(dist_cm),
        .valid  (valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   checks = 0;
    int   errors = 0;
    int   rise_cnt = 0, fall_cnt = 0, valid_cnt = 0, timeout_cnt = 0;
    int   last_rise = 0, last_fall = 0, last_valid = 0, last_to = 0, last_dist = 0;
    bit   both_seen = 1'b0;
    logic trig_q = 1'b0;

    // Event monitor sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (trig === 1'b1 && trig_q !== 1'b1) begin rise_cnt++; last_rise = cyc; end
        if (trig !== 1'b1 && trig_q === 1'b1) begin fall_cnt++; last_fall = cyc; end
        trig_q = trig;
        if (valid === 1'b1) begin valid_cnt++; last_valid = cyc; last_dist = int'(dist_cm); end
        if (timeout === 1'b1) begin timeout_cnt++; last_to = cyc; end
        if (valid === 1'b1 && timeout === 1'b1) both_seen = 1'b1;
    end

    // Reference: cm = floor(echo_us / CM_US), echo_us = floor(width_clk / US_DIV), saturated.
    int hist[$];
    int model_dist = 0;

    function automatic int model_push(input int w);
        int raw;
        int s;
        raw = (w / US_DIV) / CM_US;
        if (raw > (1 << DIST_W) - 1) raw = (1 << DIST_W) - 1;
`ifdef CHAO_AVG_EN
        if (hist.size() == 0) begin
            repeat (4) hist.push_front(raw);
        end else begin
            hist.push_front(raw);
            void'(hist.pop_back());
        end
        s = 0;
        foreach (hist[i]) s += hist[i];
        return s / 4;
`else
        s = raw;
        return s;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_rise();
        int rc;
        int k;
        rc = rise_cnt;
        k  = 0;
        while (rise_cnt == rc && k < PERIOD_CYCLES + 100) begin
            step(1);
            k++;
        end
        check("trig_rise_seen", 32'(rise_cnt != rc), 1);
    endtask

    task automatic wait_fall();
        int fc;
        int k;
        fc = fall_cnt;
        k  = 0;
        while (fall_cnt == fc && k < TRIG_CYCLES + 100) begin
            step(1);
            k++;
        end
        check("trig_fall_seen", 32'(fall_cnt != fc), 1);
    endtask

    task automatic shot(input string tag, input int d, input int w,
                        input bit drop_en, input bit glitch, input bit chk_period);
        int pr;
        int vc;
        int tc;
        int ef;
        pr = last_rise;
        wait_rise();
        if (chk_period) check({tag, "_period"}, last_rise - pr, PERIOD_CYCLES);
        wait_fall();
        check({tag, "_trig_len"}, last_fall - last_rise, TRIG_CYCLES);
        vc = valid_cnt;
        tc = timeout_cnt;
        step(d);
        echo = 1'b1;
        step(w / 2);
        if (drop_en) en = 1'b0;
        step(w - w / 2);
        echo = 1'b0;
        ef = cyc;
        if (glitch) begin
            step(4);
            echo = 1'b1;
            step(20);
            echo = 1'b0;
        end
        step(8);
        model_dist = model_push(w);
        check({tag, "_valid_cnt"}, valid_cnt, vc + 1);
        check({tag, "_dist"}, last_dist, model_dist);
        check({tag, "_latency"}, last_valid - ef, LAT);
        check({tag, "_no_timeout"}, timeout_cnt, tc);
        check({tag, "_dist_held"}, int'(dist_cm), model_dist);
    endtask

    task automatic shot_timeout(input string tag, input bit stuck);
        int pr;
        int vc;
        int tc;
        pr = last_rise;
        wait_rise();
        check({tag, "_period"}, last_rise - pr, PERIOD_CYCLES);
        vc = valid_cnt;
        tc = timeout_cnt;
        if (stuck) begin
            step(3);
            echo = 1'b1;
        end
        wait_fall();
        step(TIMEOUT_CYCLES + 10);
        check({tag, "_to_cnt"}, timeout_cnt, tc + 1);
        check({tag, "_to_time"}, last_to - last_fall, TIMEOUT_CYCLES);
        check({tag, "_no_valid"}, valid_cnt, vc);
        check({tag, "_dist_kept"}, int'(dist_cm), model_dist);
        echo = 1'b0;
    endtask

    initial begin
        int r;
        int rc;
        rst_n = 1'b0;
        en    = 1'b0;
        echo  = 1'b0;
        step(4);
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_dist", dist_cm, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        step(5);
        check("idle_busy", busy, 0);
        check("idle_no_trig", rise_cnt, 0);

        en = 1'b1;
        shot("w232", 40, 232, 1'b0, 1'b0, 1'b0);
        shot("w230", 25, 230, 1'b0, 1'b0, 1'b1);
        shot_timeout("no_echo", 1'b0);
        shot_timeout("stuck_echo", 1'b1);
        shot("w116", 60, 116, 1'b0, 1'b0, 1'b1);
        shot("w115", 15, 115, 1'b0, 1'b0, 1'b1);
        shot("w500", 60, 500, 1'b0, 1'b0, 1'b1);
        shot("glitch", 30, 300, 1'b0, 1'b1, 1'b1);
        shot("en_drop", 30, 400, 1'b1, 1'b0, 1'b1);

        r = last_rise;
        while (cyc < r + PERIOD_CYCLES - 1) step(1);
        check("en_drop_busy_last", busy, 1);
        step(1);
        check("en_drop_busy_end", busy, 0);
        check("en_drop_trig_end", trig, 0);
        rc = rise_cnt;
        step(PERIOD_CYCLES + 200);
        check("en_drop_no_trig", rise_cnt, rc);

        en = 1'b1;
        shot("restart", 10, 350, 1'b0, 1'b0, 1'b0);

        wait_rise();
        wait_fall();
        step(20);
        echo = 1'b1;
        step(60);
        rst_n = 1'b0;
        #1;
        check("midrst_trig", trig, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dist", dist_cm, 0);
        check("midrst_valid", valid, 0);
        hist.delete();
        model_dist = 0;
        step(3);
        echo  = 1'b0;
        rst_n = 1'b1;
        shot("after_rst", 30, 232, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            shot("rnd", int'($urandom_range(2, 200)), int'($urandom_range(1, 700)),
                 1'b0, 1'b0, 1'b1);
        end

        check("valid_timeout_overlap", both_seen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
